lcd_lh507x_rx: RTL and testbench

Receiver for the LH507x-style LCD panel interface. It samples the external panel signals `lcd_clk`, `lcd_latch`, `lcd_altsig`, `lcd_ctrl`, `lcd_hsync`, `lcd_vsync` and `lcd_data` with the system clock and reconstructs a 160x144 2-bit pixel stream with coordinates. It sits at the capture side of the system, for example feeding a framebuffer or a scaler from a real handheld's LCD connector or from our own panel driver in loopback. It also reports frame and line framing errors.

---
 rtl/lcd_lh507x_rx.sv | 191 +++++++++++++++++++
 tb/tb_lcd_lh507x_rx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_lh507x_rx.sv
`default_nettype none
// ============================================================================
// Module : lcd_lh507x_rx
// Brief  : LH507x-style LCD panel receiver; rebuilds pixel stream + framing errors.
// Rev    : 1.0 - initial release
// ============================================================================
module lcd_lh507x_rx #(
   parameter int H_PIXELS = 160,
   parameter int V_LINES  = 144
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       lcd_clk,
   input  logic       lcd_latch,
   input  logic       lcd_altsig,
   input  logic       lcd_ctrl,
   input  logic       lcd_hsync,
   input  logic       lcd_vsync,
   input  logic [1:0] lcd_data,
   input  logic       clr_err,
   output logic       disp_on,
   output logic       px_valid,
   output logic [1:0] px,
   output logic [7:0] px_x,
   output logic [7:0] px_y,
   output logic       frame_start,
   output logic       line_done,
   output logic       err_line,
   output logic       err_frame,
   output logic       err_alt
);
   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_wait   = 2'd1;
   localparam logic [1:0] c_st_active = 2'd2;
   localparam logic [7:0] c_h         = 8'(H_PIXELS);
   localparam logic [7:0] c_v         = 8'(V_LINES);

   // Pin vector: [7] ctrl, [6] altsig, [5] vsync, [4] hsync, [3] latch, [2] lcd_clk, [1:0] data
   logic [7:0] w_pins;
   logic [7:0] r_sync1, r_sync2;
   logic [4:0] r_sync3;
   logic       r_pclk_fall, r_latch_rise, r_hs_rise, r_vs_rise;
   logic [1:0] r_data;
   logic       w_ctrl, w_alt;

   logic [1:0] r_state, w_state_nxt;
   logic       w_in_wait, w_in_active;

   logic [7:0] r_x, r_y, w_x_nxt, w_y_nxt, w_x_tmp;
   logic       r_alt_rec;
   logic       w_pix, w_fs, w_ld, w_ev_line, w_ev_frame, w_ev_alt;

   logic       r_disp_on, r_px_valid, r_frame_start, r_line_done;
   logic [1:0] r_px;
   logic [7:0] r_px_x, r_px_y;
   logic       r_err_line, r_err_frame, r_err_alt;

   assign w_pins = {lcd_ctrl, lcd_altsig, lcd_vsync, lcd_hsync, lcd_latch, lcd_clk, lcd_data};
   assign w_ctrl = r_sync2[7];
   assign w_alt  = r_sync3[4];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1      <= '0;
         r_sync2      <= '0;
         r_sync3      <= '0;
         r_pclk_fall  <= 1'b0;
         r_latch_rise <= 1'b0;
         r_hs_rise    <= 1'b0;
         r_vs_rise    <= 1'b0;
         r_data       <= '0;
      end else begin
         r_sync1      <= w_pins;
         r_sync2      <= r_sync1;
         r_sync3      <= r_sync2[6:2];
         r_pclk_fall  <= ~r_sync2[2] &  r_sync3[0];
         r_latch_rise <=  r_sync2[3] & ~r_sync3[1];
         r_hs_rise    <=  r_sync2[4] & ~r_sync3[2];
         r_vs_rise    <=  r_sync2[5] & ~r_sync3[3];
         r_data       <=  r_sync2[1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= c_st_idle;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!w_ctrl) begin
         w_state_nxt = c_st_idle;
      end else begin
         case (r_state)
            c_st_idle:   w_state_nxt = c_st_wait;
            c_st_wait:   if (r_vs_rise) w_state_nxt = c_st_active;
            c_st_active: w_state_nxt = c_st_active;
            default:     w_state_nxt = c_st_idle;
         endcase
      end
   end

   always_comb begin
      w_in_wait   = (r_state == c_st_wait);
      w_in_active = (r_state == c_st_active);
   end

   // Same-cycle priority: vsync masks latch/hsync; pixel counts before latch; hsync clears last.
   always_comb begin
      w_x_nxt    = r_x;
      w_y_nxt    = r_y;
      w_x_tmp    = r_x;
      w_pix      = 1'b0;
      w_fs       = 1'b0;
      w_ld       = 1'b0;
      w_ev_line  = 1'b0;
      w_ev_frame = 1'b0;
      w_ev_alt   = 1'b0;
      if (!w_ctrl) begin
         w_x_nxt = '0;
         w_y_nxt = '0;
      end else if ((w_in_wait || w_in_active) && r_vs_rise) begin
         w_ev_frame = w_in_active && (r_y != c_v);
         w_ev_alt   = w_in_active && (w_alt == r_alt_rec);
         w_x_nxt    = '0;
         w_y_nxt    = '0;
         w_fs       = 1'b1;
      end else if (w_in_active) begin
         if (r_pclk_fall) begin
            if (r_y >= c_v)     w_ev_frame = 1'b1;
            else if (r_x < c_h) w_pix      = 1'b1;
            w_x_tmp = (r_x == 8'hFF) ? r_x : r_x + 8'd1;
         end
         if (r_latch_rise) begin
            w_ev_line = (w_x_tmp != c_h);
            w_ld      = 1'b1;
            w_x_tmp   = '0;
            w_y_nxt   = (r_y == 8'hFF) ? r_y : r_y + 8'd1;
         end
         if (r_hs_rise) w_x_tmp = '0;
         w_x_nxt = w_x_tmp;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_x           <= '0;
         r_y           <= '0;
         r_alt_rec     <= 1'b0;
         r_disp_on     <= 1'b0;
         r_px_valid    <= 1'b0;
         r_frame_start <= 1'b0;
         r_line_done   <= 1'b0;
         r_px          <= '0;
         r_px_x        <= '0;
         r_px_y        <= '0;
         r_err_line    <= 1'b0;
         r_err_frame   <= 1'b0;
         r_err_alt     <= 1'b0;
      end else begin
         r_x           <= w_x_nxt;
         r_y           <= w_y_nxt;
         r_disp_on     <= w_ctrl;
         r_px_valid    <= w_pix;
         r_frame_start <= w_fs;
         r_line_done   <= w_ld;
         if (w_fs) r_alt_rec <= w_alt;
         if (w_pix) begin
            r_px   <= r_data;
            r_px_x <= r_x;
            r_px_y <= r_y;
         end
         // An error event in the same cycle as clr_err keeps the flag set.
         r_err_line  <= w_ev_line  | (r_err_line  & ~clr_err);
         r_err_frame <= w_ev_frame | (r_err_frame & ~clr_err);
         r_err_alt   <= w_ev_alt   | (r_err_alt   & ~clr_err);
      end
   end

   assign disp_on     = r_disp_on;
   assign px_valid    = r_px_valid;
   assign px          = r_px;
   assign px_x        = r_px_x;
   assign px_y        = r_px_y;
   assign frame_start = r_frame_start;
   assign line_done   = r_line_done;
   assign err_line    = r_err_line;
   assign err_frame   = r_err_frame;
   assign err_alt     = r_err_alt;
endmodule
`default_nettype wire

// File: tb/tb_lcd_lh507x_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_lh507x_rx
// Brief  : Randomized self-checking bench for lcd_lh507x_rx with an event-level model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_lcd_lh507x_rx;
   localparam int c_h = 20;
   localparam int c_v = 6;
   localparam int c_idle = 0, c_wait = 1, c_act = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       lcd_clk = 0, lcd_latch = 0, lcd_altsig = 0, lcd_ctrl = 0;
   logic       lcd_hsync = 0, lcd_vsync = 0, clr_err = 0;
   logic [1:0] lcd_data = 0;
   logic       disp_on, px_valid, frame_start, line_done, err_line, err_frame, err_alt;
   logic [1:0] px;
   logic [7:0] px_x, px_y;

   lcd_lh507x_rx #(.H_PIXELS(c_h), .V_LINES(c_v)) dut (
      .clk(clk), .reset(reset), .lcd_clk(lcd_clk), .lcd_latch(lcd_latch),
      .lcd_altsig(lcd_altsig), .lcd_ctrl(lcd_ctrl), .lcd_hsync(lcd_hsync),
      .lcd_vsync(lcd_vsync), .lcd_data(lcd_data), .clr_err(clr_err),
      .disp_on(disp_on), .px_valid(px_valid), .px(px), .px_x(px_x), .px_y(px_y),
      .frame_start(frame_start), .line_done(line_done), .err_line(err_line),
      .err_frame(err_frame), .err_alt(err_alt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Event-level model of the receiver
   typedef struct { int x; int y; int d; } pix_t;
   pix_t exp_q[$];
   int   m_state = c_idle, mx = 0, my = 0, exp_ld = 0, exp_fs = 0;
   bit   m_rec = 0, m_el = 0, m_ef = 0, m_ea = 0;

   function automatic void m_pixel(int d);
      if (m_state == c_act) begin
         if (my >= c_v)     m_ef = 1;
         else if (mx < c_h) exp_q.push_back('{mx, my, d});
         mx = (mx >= 255) ? 255 : mx + 1;
      end
   endfunction

   function automatic void m_latch();
      if (m_state == c_act) begin
         if (mx != c_h) m_el = 1;
         exp_ld++;
         mx = 0;
         my = (my >= 255) ? 255 : my + 1;
      end
   endfunction

   function automatic void m_hsync();
      if (m_state == c_act) mx = 0;
   endfunction

   function automatic void m_vsync(bit alt);
      if (m_state == c_act) begin
         if (my != c_v)   m_ef = 1;
         if (alt == m_rec) m_ea = 1;
      end
      if (m_state != c_idle) begin
         mx = 0; my = 0; exp_fs++; m_rec = alt; m_state = c_act;
      end
   endfunction

   function automatic void m_ctrl(bit v);
      if (!v) begin m_state = c_idle; mx = 0; my = 0; end
      else if (m_state == c_idle) m_state = c_wait;
   endfunction

   // Compare process
   int cnt_px = 0, cnt_ld = 0, cnt_fs = 0, last_x = 0, last_y = 0, last_px = 0;
   always @(posedge clk) begin
      #1;
      if (reset === 1'b1) begin
         if (px_valid === 1'b1) begin
            cnt_px++;
            check("px_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               pix_t e;
               e = exp_q.pop_front();
               check("px_x", int'(px_x), e.x);
               check("px_y", int'(px_y), e.y);
               check("px", int'(px), e.d);
            end
            last_x = px_x; last_y = px_y; last_px = px;
         end
         if (line_done === 1'b1)   cnt_ld++;
         if (frame_start === 1'b1) cnt_fs++;
      end
   end

   task automatic hold(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pixel(int d);
      lcd_data = 2'(d); lcd_clk = 1; hold(4);
      lcd_clk = 0; m_pixel(d); hold(4);
   endtask

   task automatic hsync_pulse();
      lcd_hsync = 1; m_hsync(); hold(4); lcd_hsync = 0; hold(4);
   endtask

   task automatic latch_pulse();
      lcd_latch = 1; m_latch(); hold(4); lcd_latch = 0; hold(4);
   endtask

   task automatic line(int n, bit xdata);
      hsync_pulse();
      for (int i = 0; i < n; i++) pixel(xdata ? (i & 3) : int'($urandom_range(0, 3)));
      latch_pulse();
   endtask

   task automatic vsync(bit toggle);
      if (toggle) begin lcd_altsig = ~lcd_altsig; hold(4); end
      lcd_vsync = 1; m_vsync(lcd_altsig); hold(4); lcd_vsync = 0; hold(4);
   endtask

   task automatic check_model(string tag);
      hold(4);
      check({tag, "_err_line"},  int'(err_line),  int'(m_el));
      check({tag, "_err_frame"}, int'(err_frame), int'(m_ef));
      check({tag, "_err_alt"},   int'(err_alt),   int'(m_ea));
      check({tag, "_disp_on"},   int'(disp_on),   int'(lcd_ctrl));
      check({tag, "_line_done"}, cnt_ld, exp_ld);
      check({tag, "_frame_st"},  cnt_fs, exp_fs);
      check({tag, "_px_left"},   exp_q.size(), 0);
   endtask

   task automatic clear_errors();
      clr_err = 1; hold(1); clr_err = 0;
      m_el = 0; m_ef = 0; m_ea = 0;
      hold(1);
      check("clr_err_flags", int'({err_line, err_frame, err_alt}), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int px0, ld0, fs0, nl, len, r;
      #2 reset = 0;
      hold(3);
      check("reset_outputs", int'({disp_on, px_valid, px, px_x, px_y, frame_start,
                                   line_done, err_line, err_frame, err_alt}), 0);
      reset = 1; hold(2);

      lcd_ctrl = 1; m_ctrl(1); hold(6);
      check("disp_on_lock", int'(disp_on), 1);

      // Pixels before the first vsync are ignored
      px0 = cnt_px;
      for (int i = 0; i < 3; i++) pixel(i);
      check("pre_vsync_px", cnt_px - px0, 0);
      vsync(1);
      check_model("first_vsync");

      // Nominal frame with data = x[1:0]
      px0 = cnt_px; ld0 = cnt_ld;
      for (int l = 0; l < c_v; l++) line(c_h, 1);
      vsync(1);
      check_model("nominal");
      check("nominal_px_count", cnt_px - px0, 120);
      check("nominal_ld_count", cnt_ld - ld0, 6);
      check("nominal_last_x", last_x, 19);
      check("nominal_last_y", last_y, 5);
      check("nominal_last_px", last_px, 3);
      check("nominal_no_err", int'({err_line, err_frame, err_alt}), 0);

      // Short line: 4-cycle flag latency, and the event beats a same-cycle clr_err
      hsync_pulse();
      for (int i = 0; i < c_h - 1; i++) pixel(int'($urandom_range(0, 3)));
      lcd_latch = 1; m_latch(); hold(3);
      check("short_err_line_early", int'(err_line), 0);
      clr_err = 1; hold(1); clr_err = 0;
      check("short_err_line_at4", int'(err_line), 1);
      hold(3); lcd_latch = 0; hold(10);
      check("short_err_line_sticky", int'(err_line), 1);
      check_model("short");
      clear_errors();

      // Overlong line
      px0 = cnt_px;
      line(c_h + 2, 0);
      check_model("overlong");
      check("overlong_px_count", cnt_px - px0, 20);
      clear_errors();

      // Frame with too few lines, then a frame without altsig toggle
      vsync(1); check_model("resync"); clear_errors();
      for (int l = 0; l < c_v - 1; l++) line(c_h, 0);
      vsync(1);
      check_model("short_frame");
      check("short_frame_err", int'(err_frame), 1);
      clear_errors();
      for (int l = 0; l < c_v; l++) line(c_h, 0);
      vsync(0);
      check_model("no_alt");
      check("no_alt_err", int'({err_frame, err_alt}), 1);
      clear_errors();

      // vsync and latch rising together
      line(c_h, 0);
      hsync_pulse();
      for (int i = 0; i < 4; i++) pixel(int'($urandom_range(0, 3)));
      lcd_altsig = ~lcd_altsig; hold(4);
      ld0 = cnt_ld; fs0 = cnt_fs;
      lcd_vsync = 1; lcd_latch = 1; m_vsync(lcd_altsig); hold(4);
      lcd_vsync = 0; lcd_latch = 0; hold(4);
      check("simul_fs", cnt_fs - fs0, 1);
      check("simul_ld", cnt_ld - ld0, 0);
      pixel(2);
      check("simul_px_y", int'(px_y), 0);
      check("simul_px_x", int'(px_x), 0);
      check_model("simul");
      clear_errors();

      // ctrl drops mid-line
      hsync_pulse();
      for (int i = 0; i < 5; i++) pixel(int'($urandom_range(0, 3)));
      lcd_ctrl = 0; m_ctrl(0); hold(6);
      check("unlock_disp_on", int'(disp_on), 0);
      check("unlock_no_err", int'({err_line, err_frame, err_alt}), 0);
      px0 = cnt_px;
      pixel(1);
      lcd_ctrl = 1; m_ctrl(1); hold(6);
      pixel(3);
      check("unlock_no_px", cnt_px - px0, 0);
      vsync(1);
      check_model("relock");

      // Randomized frames
      for (int f = 0; f < 6; f++) begin
         r  = int'($urandom_range(0, 2));
         nl = c_v - 1 + r;
         for (int l = 0; l < nl; l++) begin
            r   = int'($urandom_range(0, 4));
            len = (r == 3) ? c_h - 1 : (r == 4) ? c_h + 2 : c_h;
            line(len, 0);
         end
         check_model("rand_frame");
         vsync($urandom_range(0, 3) != 0);
         check_model("rand_vsync");
         clear_errors();
      end

      // Asynchronous reset mid-line
      vsync(1);
      hsync_pulse();
      for (int i = 0; i < 5; i++) pixel(int'($urandom_range(0, 3)));
      check("pre_reset_px_x", int'(px_x), 4);
      #2 reset = 0;
      #1;
      check("async_reset_outputs", int'({disp_on, px_valid, px, px_x, px_y, frame_start,
                                         line_done, err_line, err_frame, err_alt}), 0);
      m_state = c_idle; mx = 0; my = 0; m_el = 0; m_ef = 0; m_ea = 0; m_rec = 0;
      hold(2);
      reset = 1; m_ctrl(lcd_ctrl); hold(6);
      px0 = cnt_px;
      pixel(2);
      check("post_reset_no_px", cnt_px - px0, 0);
      vsync(1);
      line(c_h, 0);
      check_model("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
